pe_array_ctrl: RTL and testbench



---
 rtl/pe_ctrl_pkg.sv | 23 ++
 rtl/pe_array_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pe_array_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_ctrl_pkg
// Brief    : Shared state encoding and datapath widths for the PE-array controller.
// Revision : 1.0
// ============================================================================
package pe_ctrl_pkg;

    localparam int NUM_PE_DEF = 4;
    localparam int IFMAP_W    = 8;
    localparam int WEIGHT_W   = 8;
    localparam int PROD_W     = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        COMPUTE = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } ctrl_state_e;

endpackage : pe_ctrl_pkg
`default_nettype wire

// File: rtl/pe_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pe_array_ctrl
// Brief    : Load-weights / stream-ifmap / flush sequencer for a 1-D PE chain.
// Revision : 1.0
// ============================================================================
module pe_array_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int NUM_PE = NUM_PE_DEF,
    parameter int LEN_W  = 8,
    parameter int IDX_W  = $clog2(NUM_PE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              w_valid,
    output logic              w_ready,
    output logic [NUM_PE-1:0] weight_en,
    input  logic              if_valid,
    output logic              if_ready,
    output logic              if_zero,
    output logic              prod_out_en,
    output logic              red_valid,
    output logic              busy,
    output logic              done
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_PE - 1);
    localparam logic [IDX_W-1:0] c_last_drn = IDX_W'(NUM_PE - 2);

    ctrl_state_e      state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [IDX_W-1:0] w_idx_q, w_idx_d;
    logic [LEN_W-1:0] if_cnt_q, if_cnt_d;
    logic [IDX_W-1:0] drn_cnt_q, drn_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             red_valid_q, red_valid_d;

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            w_idx_q     <= '0;
            if_cnt_q    <= '0;
            drn_cnt_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            red_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            w_idx_q     <= w_idx_d;
            if_cnt_q    <= if_cnt_d;
            drn_cnt_q   <= drn_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            red_valid_q <= red_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        w_idx_d   = w_idx_q;
        if_cnt_d  = if_cnt_q;
        drn_cnt_d = drn_cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d     = cfg_len;
                    w_idx_d   = '0;
                    if_cnt_d  = '0;
                    drn_cnt_d = '0;
                    state_d   = LOAD_W;
                end
            end
            LOAD_W: begin
                // w_ready is constantly high here, so w_valid alone is the handshake
                if (w_valid) begin
                    w_idx_d = w_idx_q + IDX_W'(1);
                    if (w_idx_q == c_last_idx) begin
                        state_d = (len_q == '0) ? DONE : COMPUTE;
                    end
                end
            end
            COMPUTE: begin
                if (if_valid) begin
                    if_cnt_d = if_cnt_q + LEN_W'(1);
                    if (if_cnt_q == len_q - LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                drn_cnt_d = drn_cnt_q + IDX_W'(1);
                if (drn_cnt_q == c_last_drn) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags are registered from the decoded next state so they
        // line up exactly with state_q.
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        red_valid_d = prod_out_en;
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_ready     = 1'b0;
        weight_en   = '0;
        if_ready    = 1'b0;
        if_zero     = 1'b0;
        prod_out_en = 1'b0;

        case (state_q)
            LOAD_W: begin
                w_ready   = 1'b1;
                weight_en = w_valid ? (NUM_PE'(1) << w_idx_q) : '0;
            end
            COMPUTE: begin
                // A bubble leaves the chain frozen rather than shifting stale data
                if_ready    = 1'b1;
                prod_out_en = if_valid;
            end
            DRAIN: begin
                if_zero     = 1'b1;
                prod_out_en = 1'b1;
            end
            default: begin
                w_ready = 1'b0;
            end
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign red_valid = red_valid_q;

endmodule : pe_array_ctrl
`default_nettype wire

// File: tb/tb_pe_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_array_ctrl
// Brief    : Directed self-checking bench for the PE-array controller.
// Revision : 1.0
// ============================================================================
module tb_pe_array_ctrl;

    localparam int NUM_PE = 4;
    localparam int LEN_W  = 8;

    logic              clk;
    logic              reset;
    logic              start;
    logic [LEN_W-1:0]  cfg_len;
    logic              w_valid;
    logic              w_ready;
    logic [NUM_PE-1:0] weight_en;
    logic              if_valid;
    logic              if_ready;
    logic              if_zero;
    logic              prod_out_en;
    logic              red_valid;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_errors = 0;

    pe_array_ctrl #(
        .NUM_PE (NUM_PE),
        .LEN_W  (LEN_W)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cfg_len     (cfg_len),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .weight_en   (weight_en),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_zero     (if_zero),
        .prod_out_en (prod_out_en),
        .red_valid   (red_valid),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({w_ready, weight_en, if_ready, if_zero, prod_out_en, red_valid, busy, done});
    endfunction

    // One job from the start cycle (cyc 0) until done or a reset abort.
    // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
    task automatic run_job(input int len, input bit stall, input int inj_cyc, input int abort_cyc,
                           output int done_cyc, output int n_w, output int n_comp,
                           output int n_drain, output int n_red);
        logic prev_poe;
        int   seq_err;
        done_cyc = -1;
        n_w      = 0;
        n_comp   = 0;
        n_drain  = 0;
        n_red    = 0;
        prev_poe = 1'b0;
        seq_err  = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            start    = (cyc == 0) || (cyc == inj_cyc);
            cfg_len  = (cyc == 0) ? LEN_W'(len) : LEN_W'(9);
            w_valid  = stall ? cyc[0] : 1'b1;
            if_valid = stall ? ~cyc[0] : 1'b1;
            @(negedge clk);
            if (cyc == 0) check("idle_busy", 32'(busy), 32'd0);
            if (weight_en != '0) begin
                check("weight_en", 32'(weight_en), 32'd1 << n_w);
                if (!w_valid || !w_ready) seq_err++;
                n_w++;
            end
            if (prod_out_en) begin
                if (!if_zero) begin
                    if (!if_valid || !if_ready) seq_err++;
                    n_comp++;
                end else begin
                    if (if_ready) seq_err++;
                    n_drain++;
                end
            end
            if (red_valid !== prev_poe) seq_err++;
            if (red_valid) n_red++;
            prev_poe = prod_out_en;
            if (cyc == abort_cyc) begin
                #1 reset = 1'b1;
                #1 check("async_rst_outs", all_outs(), 32'd0);
                @(posedge clk);
                #1 check("rst_edge_outs", all_outs(), 32'd0);
                reset = 1'b0;
                start = 1'b0;
                break;
            end
            if (done) begin
                done_cyc = cyc;
                @(posedge clk);
                #1;
                start = 1'b0;
                check("done_one_cycle", 32'({done, busy}), 32'd0);
                break;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("seq_rules", 32'(seq_err), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_job(input string tag, input int len, input bit stall, input int inj,
                              input int exp_done, input int exp_comp, input int exp_drain);
        int d, w, c, dr, r;
        run_job(len, stall, inj, -1, d, w, c, dr, r);
        check({tag, "_done_cyc"}, 32'(d), 32'(exp_done));
        check({tag, "_wloads"}, 32'(w), 32'(NUM_PE));
        check({tag, "_comp"}, 32'(c), 32'(exp_comp));
        check({tag, "_drain"}, 32'(dr), 32'(exp_drain));
        check({tag, "_red"}, 32'(r), 32'(exp_comp + exp_drain));
    endtask

    initial begin
        int d, w, c, dr, r;
        reset    = 1'b1;
        start    = 1'b0;
        cfg_len  = '0;
        w_valid  = 1'b0;
        if_valid = 1'b0;
        #12;
        check("reset_outs", all_outs(), 32'd0);
        #10 reset = 1'b0;
        @(posedge clk);
        #1;

        // Nominal: 1+4+3+3+1 = 12 cycles inclusive, done at offset 11
        expect_job("nominal", 3, 1'b0, -1, 11, 3, 3);
        idle_cycles(2);

        // Stalls: loads at 1,3,5,7; ifmap at 8,10,12,14,16; drain 17-19; done 20
        expect_job("stall", 5, 1'b1, -1, 20, 5, 3);
        idle_cycles(2);

        // Zero length: loads 1-4, done at 5
        expect_job("len0", 0, 1'b0, -1, 5, 0, 0);
        idle_cycles(2);

        // Start with cfg_len=9 at cycle 5 (COMPUTE) must be ignored
        expect_job("busy_start", 2, 1'b0, 5, 10, 2, 3);
        // Back-to-back: start the cycle after done, own length 1
        expect_job("b2b", 1, 1'b0, -1, 9, 1, 3);
        idle_cycles(2);

        // Reset mid-COMPUTE (len 6, compute 5..10) and mid-DRAIN (len 2, drain 7..9)
        run_job(6, 1'b0, -1, 6, d, w, c, dr, r);
        check("abort_comp_cnt", 32'(c), 32'd2);
        idle_cycles(1);
        expect_job("post_rst1", 3, 1'b0, -1, 11, 3, 3);
        idle_cycles(1);
        run_job(2, 1'b0, -1, 8, d, w, c, dr, r);
        check("abort_drain_cnt", 32'(dr), 32'd2);
        idle_cycles(1);
        expect_job("post_rst2", 3, 1'b0, -1, 11, 3, 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pe_array_ctrl
`default_nettype wire
